dpic_mem_master: RTL and testbench

Initiator side of the simulation memory port: accepts one load/store request at a time from the core's memory stage over a valid/ready handshake and drives the DPI-C memory model's read/write port. Range-checks each access. Reads are issued at 8-byte-aligned addresses and the addressed bytes are extracted and sign- or zero-extended. Writes are issued as single length-coded strobes. Returns one response per request, also over a valid/ready handshake.

---
 rtl/dpic_mem_master.sv | 170 +++++++++++++++++
 tb/tb_dpic_mem_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpic_mem_master.sv
// rtl/dpic_mem_master.sv - load/store initiator driving the DPI-C memory read/write port
// Define MEM_MISALIGN_EN to allow misaligned accesses; crossing loads then take two read beats.
module dpic_mem_master #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_t;

  state_t      state;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        cross_q;
  logic [63:0] d0_q;

  logic [3:0]  len;
  logic [63:0] last;
  logic [63:0] top;
  logic        range_err;
  logic        acc_err;
  logic        crossing;
  logic [7:0]  len_mask;
  logic [63:0] wdata_masked;

  assign req_ready = (state == IDLE) && !reset;

  always_comb begin
    len       = 4'd1 << req_size;
    top       = MEM_BASE + MEM_SIZE - 64'd1;
    last      = req_addr + {60'd0, len} - 64'd1;
    // last < req_addr catches address wrap past the top of the 64-bit space
    range_err = (req_addr < MEM_BASE) || (last > top) || (last < req_addr);
`ifdef MEM_MISALIGN_EN
    crossing  = ({1'b0, req_addr[2:0]} + len) > 4'd8;
    acc_err   = range_err;
`else
    crossing  = 1'b0;
    acc_err   = range_err || ((req_addr[2:0] & (len[2:0] - 3'd1)) != 3'd0);
`endif
    case (req_size)
      2'd0:    len_mask = 8'h01;
      2'd1:    len_mask = 8'h03;
      2'd2:    len_mask = 8'h0F;
      default: len_mask = 8'hFF;
    endcase
    wdata_masked = '0;
    for (int i = 0; i < 8; i++)
      wdata_masked[8*i +: 8] = len_mask[i] ? req_wdata[8*i +: 8] : 8'h00;
  end

  // Shift the two-beat window down to the addressed byte, then truncate and extend.
  function automatic logic [63:0] extend(input logic [127:0] pair, input logic [2:0] off,
                                         input logic [1:0] size, input logic sgn);
    logic [63:0] raw;
    raw = pair[{off, 3'b000} +: 64];
    case (size)
      2'd0:    return {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    return {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    return {{32{sgn & raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      cross_q     <= 1'b0;
      d0_q        <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_we_en   <= 1'b0;
      mem_we_addr <= '0;
      mem_we_data <= '0;
      mem_we_mask <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          off_q   <= req_addr[2:0];
          size_q  <= req_size;
          sgn_q   <= req_signed;
          cross_q <= crossing;
          if (acc_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else if (req_wen) begin
            mem_we_en   <= 1'b1;
            mem_we_addr <= req_addr;
            mem_we_data <= wdata_masked;
            mem_we_mask <= len_mask;
            state       <= WR;
          end else begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= {req_addr[63:3], 3'b000};
            state       <= RD0;
          end
        end
        RD0: begin
          d0_q <= mem_rd_data;
          if (cross_q) begin
            mem_rd_addr <= mem_rd_addr + 64'd8;
            state       <= RD1;
          end else begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b0;
            resp_rdata  <= extend({64'd0, mem_rd_data}, off_q, size_q, sgn_q);
            state       <= RESP;
          end
        end
        RD1: begin
          mem_rd_en   <= 1'b0;
          mem_rd_addr <= '0;
          resp_valid  <= 1'b1;
          resp_err    <= 1'b0;
          resp_rdata  <= extend({mem_rd_data, d0_q}, off_q, size_q, sgn_q);
          state       <= RESP;
        end
        WR: begin
          mem_we_en   <= 1'b0;
          mem_we_addr <= '0;
          mem_we_data <= '0;
          mem_we_mask <= '0;
          resp_valid  <= 1'b1;
          resp_err    <= 1'b0;
          resp_rdata  <= '0;
          state       <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpic_mem_master.sv
// tb/tb_dpic_mem_master.sv - self-checking bench for dpic_mem_master
// Byte-level memory models: dmem is written by DUT strobes, rmem by the reference scoreboard.
module tb_dpic_mem_master;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;

  logic        clock, reset;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;

  dpic_mem_master #(.MEM_BASE(BASE), .MEM_SIZE(SIZE)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we_en(mem_we_en),
    .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data), .mem_we_mask(mem_we_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic wen; logic [63:0] addr; logic [1:0] size; logic sgn; logic [63:0] wdata; } req_t;
  typedef struct { logic err; logic [63:0] rdata; int lat; logic [63:0] we_data; logic [7:0] we_mask; } exp_t;
  typedef struct {
    logic wen; logic [63:0] addr; logic [1:0] size; logic sgn; logic [63:0] wdata;
    logic pre; logic [63:0] q0; logic [63:0] q1;
    logic err; logic [63:0] rdata; int lat; logic [63:0] we_data; logic [7:0] we_mask;
  } vec_t;

  logic [7:0] dmem [logic [63:0]];
  logic [7:0] rmem [logic [63:0]];
  int dmem_ver = 0;
  int total = 0;
  int bad = 0;

  function automatic logic [7:0] init_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] dbyte(input logic [63:0] a);
    return dmem.exists(a) ? dmem[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] rbyte(input logic [63:0] a);
    return rmem.exists(a) ? rmem[a] : init_byte(a);
  endfunction

  always @(mem_rd_addr or dmem_ver)
    for (int i = 0; i < 8; i++) mem_rd_data[8*i +: 8] = dbyte(mem_rd_addr + 64'(i));

  always @(posedge clock)
    if (!reset && mem_we_en) begin
      for (int i = 0; i < 8; i++)
        if (mem_we_mask[i]) dmem[mem_we_addr + 64'(i)] = mem_we_data[8*i +: 8];
      dmem_ver++;
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t model_expect(input req_t r);
    exp_t e;
    int len;
    logic [63:0] v;
    len = 1 << r.size;
    e = '{err: 1'b0, rdata: 64'd0, lat: 0, we_data: 64'd0, we_mask: 8'd0};
    e.err = (r.addr < BASE) || (r.addr + 64'(len) - 64'd1 > BASE + SIZE - 64'd1);
`ifndef MEM_MISALIGN_EN
    if (r.addr % 64'(len) != 64'd0) e.err = 1'b1;
`endif
    if (e.err) e.lat = 1;
    else if (r.wen) begin
      e.lat = 2;
      for (int i = 0; i < len; i++) begin
        e.we_data[8*i +: 8] = r.wdata[8*i +: 8];
        e.we_mask[i] = 1'b1;
      end
    end else begin
      e.lat = (int'(r.addr % 64'd8) + len > 8) ? 3 : 2;
      v = '0;
      for (int i = 0; i < len; i++) v[8*i +: 8] = rbyte(r.addr + 64'(i));
      if (r.sgn && v[8*len-1])
        for (int i = len; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic commit(input req_t r);
    for (int i = 0; i < (1 << r.size); i++) rmem[r.addr + 64'(i)] = r.wdata[8*i +: 8];
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic run_req(input req_t r, input exp_t e, input int hold, input string nm);
    int lat, nrd, nwe;
    logic [63:0] rda0, rda1, wa, wd, got_rd;
    logic [7:0] wm;
    logic got_err, stable;
    lat = 0; nrd = 0; nwe = 0; rda0 = '0; rda1 = '0; wa = '0; wd = '0; wm = '0;
    got_rd = '0; got_err = 1'b0; stable = 1'b1;
    @(negedge clock);
    req_valid = 1'b1; req_wen = r.wen; req_addr = r.addr; req_size = r.size;
    req_signed = r.sgn; req_wdata = r.wdata; resp_ready = (hold == 0);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clock);
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        // request fields must already be captured; scramble them while valid stays high
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        req_size = 2'($urandom); req_wen = 1'($urandom); req_signed = 1'($urandom);
      end
      if (mem_rd_en) begin
        if (nrd == 0) rda0 = mem_rd_addr; else rda1 = mem_rd_addr;
        nrd++;
      end
      if (mem_we_en) begin nwe++; wa = mem_we_addr; wd = mem_we_data; wm = mem_we_mask; end
      if (resp_valid) begin lat = k; got_rd = resp_rdata; got_err = resp_err; break; end
    end
    chk({nm, ".lat"}, 64'(lat), 64'(e.lat));
    if (lat == 0) begin pulse_reset(); return; end
    chk({nm, ".err"}, 64'(got_err), 64'(e.err));
    chk({nm, ".rdata"}, got_rd, e.rdata);
    chk({nm, ".nrd"}, 64'(nrd), (e.err || r.wen) ? 64'd0 : 64'(e.lat - 1));
    chk({nm, ".nwe"}, 64'(nwe), (r.wen && !e.err) ? 64'd1 : 64'd0);
    if (r.wen && !e.err) begin
      chk({nm, ".we_addr"}, wa, r.addr);
      chk({nm, ".we_data"}, wd, e.we_data);
      chk({nm, ".we_mask"}, 64'(wm), 64'(e.we_mask));
    end
    if (!r.wen && !e.err) begin
      chk({nm, ".rd_addr0"}, rda0, r.addr - (r.addr % 64'd8));
      if (e.lat == 3) chk({nm, ".rd_addr1"}, rda1, r.addr - (r.addr % 64'd8) + 64'd8);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      if (!(resp_valid && resp_rdata == got_rd && resp_err == got_err && !req_ready &&
            !mem_rd_en && !mem_we_en)) stable = 1'b0;
    end
    if (hold > 0) chk({nm, ".hold"}, 64'(stable), 64'd1);
    resp_ready = 1'b1;
    @(negedge clock);
    chk({nm, ".ready_after"}, 64'(req_ready), 64'd1);
    chk({nm, ".resp_after"}, 64'(resp_valid), 64'd0);
    chk({nm, ".rdaddr_idle"}, mem_rd_addr, 64'd0);
    req_valid = 1'b0; resp_ready = 1'b0;
    if (r.wen && !e.err) commit(r);
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] q);
    for (int i = 0; i < 8; i++) begin
      dmem[a + 64'(i)] = q[8*i +: 8];
      rmem[a + 64'(i)] = q[8*i +: 8];
    end
    dmem_ver++;
  endtask

  vec_t tbl[$];

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t  r;
    exp_t  e;
    vec_t  v;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_signed = 0; req_wdata = 0;
    resp_ready = 0; reset = 1'b1;

    tbl.push_back('{0, 64'h8000_0004, 2, 1, 0, 1, 64'hF234_5678_1122_3344, 0, 0, 64'hFFFF_FFFF_F234_5678, 2, 0, 0});
    tbl.push_back('{1, 64'h8000_0102, 1, 0, 64'hDEAD_BEEF_CAFE_1234, 0, 0, 0, 0, 0, 2, 64'h1234, 8'h03});
    tbl.push_back('{0, 64'h8000_0102, 1, 1, 0, 0, 0, 0, 0, 64'h1234, 2, 0, 0});
`ifdef MEM_MISALIGN_EN
    tbl.push_back('{0, 64'h8000_0006, 3, 0, 0, 1, 64'h8877_6655_4433_2211, 64'h1100_FFEE_DDCC_BBAA, 0, 64'hFFEE_DDCC_BBAA_8877, 3, 0, 0});
    tbl.push_back('{0, 64'h8000_0001, 1, 0, 0, 1, 64'hF234_5678_1122_3344, 0, 0, 64'h2233, 2, 0, 0});
`else
    tbl.push_back('{0, 64'h8000_0006, 3, 0, 0, 1, 64'h8877_6655_4433_2211, 64'h1100_FFEE_DDCC_BBAA, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 64'h8000_0001, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0});
`endif
    tbl.push_back('{0, 64'h7FFF_FFFC, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 64'h7FFF_FFFC, 2, 0, 64'h1234_5678, 0, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 64'h87FF_FFFE, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 64'h8000_0007, 0, 1, 0, 1, 64'hF234_5678_1122_3344, 0, 0, 64'hFFFF_FFFF_FFFF_FFF2, 2, 0, 0});
    tbl.push_back('{0, 64'h8000_0007, 0, 0, 0, 0, 0, 0, 0, 64'hF2, 2, 0, 0});
    tbl.push_back('{0, 64'h87FF_FFF8, 3, 1, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0123_4567_89AB_CDEF, 2, 0, 0});
    tbl.push_back('{1, 64'h87FF_FFFF, 0, 0, 64'h5555_AAAA_0000_11AB, 0, 0, 0, 0, 0, 2, 64'hAB, 8'h01});
    tbl.push_back('{0, 64'h8800_0000, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 64'h8000_0010, 3, 0, 64'h0011_2233_4455_6677, 0, 0, 0, 0, 0, 2, 64'h0011_2233_4455_6677, 8'hFF});

    repeat (3) @(negedge clock);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.strobes", {62'd0, mem_rd_en, mem_we_en}, 64'd0);
    chk("rst.rd_addr", mem_rd_addr, 64'd0);
    reset = 1'b0;
    #1 chk("rst.release_ready", 64'(req_ready), 64'd1);

    foreach (tbl[i]) begin
      v = tbl[i];
      r = '{v.wen, v.addr, v.size, v.sgn, v.wdata};
      e = '{v.err, v.rdata, v.lat, v.we_data, v.we_mask};
      if (v.pre) begin
        preload(v.addr - (v.addr % 64'd8), v.q0);
        preload(v.addr - (v.addr % 64'd8) + 64'd8, v.q1);
      end
      run_req(r, e, (i == 0) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // store cut by reset during its WR cycle
    @(negedge clock);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0200; req_size = 2'd2;
    req_wdata = 64'hAAAA_BBBB; resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("rstwr.we_before", 64'(mem_we_en), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstwr.we_drop", 64'(mem_we_en), 64'd0);
    chk("rstwr.resp_drop", 64'(resp_valid), 64'd0);
    chk("rstwr.mask_drop", 64'(mem_we_mask), 64'd0);
    @(negedge clock); reset = 1'b0;
    #1 chk("rstwr.ready_release", 64'(req_ready), 64'd1);
    repeat (3) begin
      @(negedge clock);
      chk("rstwr.quiet", {62'd0, mem_we_en, resp_valid}, 64'd0);
    end
    r = '{0, 64'h8000_0200, 2, 0, 0};
    run_req(r, model_expect(r), 0, "rstwr.readback");

    for (int n = 0; n < 150; n++) begin
      int sel;
      int hold;
      sel = $urandom_range(0, 9);
      r.wen = 1'($urandom);
      r.size = 2'($urandom);
      r.sgn = 1'($urandom);
      r.wdata = {$urandom, $urandom};
      case (sel)
        0: r.addr = BASE - 64'($urandom_range(1, 16));
        1: r.addr = BASE + SIZE - 64'($urandom_range(1, 12));
        2: r.addr = BASE + SIZE + 64'($urandom_range(0, 8));
        default: r.addr = BASE + 64'($urandom_range(0, 47));
      endcase
      if (sel >= 3 && $urandom_range(0, 1) == 1) r.addr = r.addr & ~(64'(1 << r.size) - 64'd1);
      hold = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
      e = model_expect(r);
      run_req(r, e, hold, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
